// File: rtl/cam_pkg.sv
// Shared constants and capture FSM state type for the camera frame-buffer path.
// FRAME_PIXELS is also used by the frame RAM and the read-side display block.
package cam_pkg;

    localparam int unsigned CAM_AW       = 17;
    localparam int unsigned CAM_DW       = 16;
    localparam int unsigned CAM_IMG_W    = 160;
    localparam int unsigned CAM_IMG_H    = 120;
    localparam int unsigned FRAME_PIXELS = CAM_IMG_W * CAM_IMG_H;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        BYTE_HI    = 2'd1,
        BYTE_LO    = 2'd2
    } cap_state_t;

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchroniser for a bus of asynchronous signals, with toggle detect on the low EDGE_W bits.
// Every bit passes through the same stage count, so data stays aligned with its strobe.
module cam_sync #(
    parameter int unsigned W      = 11,
    parameter int unsigned EDGE_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      i_d,
    output logic [W-1:0]      o_sync,
    output logic [EDGE_W-1:0] o_edge
);

    logic [W-1:0]      r_s1;
    logic [W-1:0]      r_s2;
    logic [EDGE_W-1:0] r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
            r_s3 <= r_s2[EDGE_W-1:0];
        end
    end

    // Combine with o_sync to recover direction: rise = edge & sync, fall = edge & ~sync.
    assign o_sync = r_s2;
    assign o_edge = r_s2[EDGE_W-1:0] ^ r_s3;

endmodule

// File: rtl/cam_capture.sv
// OV7670-style capture: samples the camera bus in the clk domain, packs byte pairs into RGB565
// and drives the frame RAM write port with one linear address per pixel.
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned AW    = CAM_AW,
    parameter int unsigned DW    = CAM_DW,
    parameter int unsigned IMG_W = CAM_IMG_W,
    parameter int unsigned IMG_H = CAM_IMG_H
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cam_pclk,
    input  logic          cam_href,
    input  logic          cam_vsync,
    input  logic [7:0]    cam_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          frame_done,
    output logic          overflow
);

    localparam logic [AW-1:0] LIMIT = AW'(IMG_W * IMG_H);

    logic [10:0] w_bus_in;
    logic [10:0] w_sync;
    logic [2:0]  w_edge;
    logic        w_pclk_rise;
    logic        w_href;
    logic        w_href_fall;
    logic        w_vs_rise;
    logic        w_vs_fall;
    logic [7:0]  w_byte;

    assign w_bus_in = {cam_data, cam_vsync, cam_href, cam_pclk};

    cam_sync #(
        .W      (11),
        .EDGE_W (3)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (w_bus_in),
        .o_sync (w_sync),
        .o_edge (w_edge)
    );

    assign w_pclk_rise = w_edge[0] &  w_sync[0];
    assign w_href      = w_sync[1];
    assign w_href_fall = w_edge[1] & ~w_sync[1];
    assign w_vs_rise   = w_edge[2] &  w_sync[2];
    assign w_vs_fall   = w_edge[2] & ~w_sync[2];
    assign w_byte      = w_sync[10:3];

    cap_state_t    r_state;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [7:0]    r_pix_hi;
    logic          r_regwrite;
    logic          r_frame_done;
    logic          r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= WAIT_FRAME;
            r_addr       <= '0;
            r_data       <= '0;
            r_pix_hi     <= '0;
            r_regwrite   <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_regwrite   <= 1'b0;
            r_frame_done <= 1'b0;
            // Address advances the cycle after each write, so the write cycle shows the used address.
            if (r_regwrite)
                r_addr <= r_addr + AW'(1);

            if (r_state != WAIT_FRAME && w_vs_rise) begin
                r_state      <= WAIT_FRAME;
                r_frame_done <= 1'b1;
            end else begin
                case (r_state)
                    WAIT_FRAME: begin
                        if (w_vs_fall) begin
                            r_state    <= BYTE_HI;
                            r_addr     <= '0;
                            r_overflow <= 1'b0;
                        end
                    end
                    BYTE_HI: begin
                        if (w_pclk_rise && w_href) begin
                            r_pix_hi <= w_byte;
                            r_state  <= BYTE_LO;
                        end
                    end
                    BYTE_LO: begin
                        if (w_href_fall || (w_pclk_rise && !w_href)) begin
                            r_state <= BYTE_HI;
                        end else if (w_pclk_rise) begin
                            r_state <= BYTE_HI;
                            if (r_addr == LIMIT) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_data     <= DW'({r_pix_hi, w_byte});
                                r_regwrite <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= WAIT_FRAME;
                endcase
            end
        end
    end

    assign addr_in    = r_addr;
    assign data_in    = r_data;
    assign regwrite   = r_regwrite;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule
